alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Accumulator-based sequencer that drives the 3-bit-select datapath ALU as its
//  initiator. Accepts one instruction per valid/ready handshake, drives the ALU
//  operand/select ports, captures the ALU result into an accumulator with flags,
//  and returns accumulator contents on a valid/ready result port for STORE.
// PARAMETERS
//  WIDTH      8   data, accumulator and ALU operand width (signed, two's complement)
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rstn           in   1      asynchronous active-low reset
//  s_valid        in   1      instruction valid
//  s_ready        out  1      sequencer can accept instruction
//  s_op           in   3      opcode (see BEHAVIOUR)
//  s_data         in   WIDTH  signed immediate operand
//  m_valid        out  1      STORE result valid
//  m_ready        in   1      downstream accepts result
//  m_data         out  WIDTH  signed accumulator value for STORE
//  zero           out  1      registered: acc == 0
//  negative       out  1      registered: acc < 0
//  alu_bus_a      out  WIDTH  ALU operand A
//  alu_bus_b      out  WIDTH  ALU operand B
//  alu_sel        out  3      ALU select: 000 pass A, 001 add, 010 sub, 011 mul, 100 A/2
//  alu_out        in   WIDTH  ALU result (combinational from above)
// BEHAVIOUR
//  Reset (rstn low, async): state=IDLE, acc=0, zero=1, negative=0, m_valid=0,
//   m_data=0, op_r/data_r=0; s_ready forced 0 while rstn low.
//  Opcodes (op_r latched at accept): 000 LOAD acc=data; 001 ADD acc+=data;
//   010 SUB acc-=data; 011 MUL acc*=data; 100 HALF acc=acc/2; 101 CLR acc=0;
//   110 STORE emit acc; 111 NOP.
//  ALU drive in EXEC (from registers only, stable whole cycle):
//   LOAD: sel 000, A=data_r | ADD/SUB/MUL: sel 001/010/011, A=acc, B=data_r
//   HALF: sel 100, A=acc | CLR: sel 000, A=0 | STORE/NOP: sel 000, A=acc.
//   B=0 whenever unused. Outside EXEC: sel 000, A=acc, B=0.
//  FSM:
//   IDLE: s_ready=1. s_valid&s_ready -> latch s_op/s_data, go EXEC.
//   EXEC: s_ready=0. Edge: for LOAD..CLR acc<=alu_out, zero<=(alu_out==0),
//         negative<=alu_out[WIDTH-1]. STORE: m_data<=acc, m_valid<=1, go OUT.
//         STORE/NOP leave acc and flags unchanged. Others go IDLE.
//   OUT:  s_ready=0, m_valid=1, m_data stable until m_valid&m_ready; then
//         m_valid<=0, go IDLE. m_ready high before OUT is ignored.
//  Latency: accept at edge N, acc/flags valid after edge N+1; throughput
//   1 instr / 2 cycles; STORE result visible after edge N+1, min 3 cycles/instr.
//  Arithmetic: results truncated to WIDTH LSBs (wrap, no saturation, no
//   overflow flag). MUL keeps low WIDTH bits of signed product. HALF is signed
//   divide, truncates toward zero (-7/2=-3, -1/2=0).
//  Flags reflect acc only after ops that write acc; flags never change in IDLE/OUT.
//  s_valid while s_ready=0: ignored, s_op/s_data not sampled; upstream holds.
//  Reset mid-EXEC/OUT: op abandoned, m_valid drops immediately, acc cleared.
//  Unknown states (unreachable) recover to IDLE.
// TESTING (WIDTH=8)
//  T1 LOAD 5, ADD 3, STORE, m_ready=1 -> m_data=8, zero=0, negative=0,
//     STORE m_valid high exactly 1 cycle.
//  T2 LOAD 5, SUB 7 -> acc=-2 (8'hFE), negative=1; HALF -> acc=-1;
//     HALF -> acc=0, zero=1, negative=0.
//  T3 LOAD 16, MUL 16 -> acc=0 (wrap), zero=1; LOAD 127, ADD 1 -> acc=-128,
//     negative=1; LOAD -4, MUL 3 -> acc=-12.
//  T4 LOAD 9, STORE with m_ready=0 for 5 cycles -> m_valid=1, m_data=9 stable,
//     s_ready=0 throughout; new s_valid ignored; m_ready=1 -> IDLE next cycle.
//  T5 back-to-back s_valid held high with ADD 1 x4 from CLR -> accepts every
//     2nd cycle, acc=4; NOP between -> acc/flags unchanged.
//  T6 rstn low during OUT of STORE 42 -> m_valid=0, acc=0, zero=1 immediately;
//     after release first instruction accepted normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// Accumulator sequencer acting as initiator for an external 3-bit-select ALU.
// One instruction per handshake; the ALU result is written back to the
// accumulator one cycle later, and STORE presents the accumulator on a
// valid/ready result port.
module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [2:0]       s_op,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             zero,
    output logic             negative,
    output logic [WIDTH-1:0] alu_bus_a,
    output logic [WIDTH-1:0] alu_bus_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        OUT  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_ADD   = 3'd1,
        OP_SUB   = 3'd2,
        OP_MUL   = 3'd3,
        OP_HALF  = 3'd4,
        OP_CLR   = 3'd5,
        OP_STORE = 3'd6,
        OP_NOP   = 3'd7
    } op_t;

    localparam logic [2:0] SEL_PASS = 3'b000;
    localparam logic [2:0] SEL_ADD  = 3'b001;
    localparam logic [2:0] SEL_SUB  = 3'b010;
    localparam logic [2:0] SEL_MUL  = 3'b011;
    localparam logic [2:0] SEL_HALF = 3'b100;

    state_t           state_q, state_d;
    op_t              op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] acc_q;
    logic             zero_q;
    logic             neg_q;
    logic             m_valid_q;
    logic [WIDTH-1:0] m_data_q;
    logic             accept;
    logic             writes_acc;

    assign accept     = s_valid && s_ready;
    // LOAD..CLR occupy the low opcodes; STORE and NOP leave acc alone.
    assign writes_acc = (op_q <= OP_CLR);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = (op_q == OP_STORE) ? OUT : IDLE;
            OUT:     if (m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs and ALU drive, all derived from registered state
    always_comb begin
        s_ready   = rstn && (state_q == IDLE);
        alu_sel   = SEL_PASS;
        alu_bus_a = acc_q;
        alu_bus_b = '0;
        if (state_q == EXEC) begin
            case (op_q)
                OP_LOAD: alu_bus_a = data_q;
                OP_ADD: begin
                    alu_sel   = SEL_ADD;
                    alu_bus_b = data_q;
                end
                OP_SUB: begin
                    alu_sel   = SEL_SUB;
                    alu_bus_b = data_q;
                end
                OP_MUL: begin
                    alu_sel   = SEL_MUL;
                    alu_bus_b = data_q;
                end
                OP_HALF: alu_sel   = SEL_HALF;
                OP_CLR:  alu_bus_a = '0;
                default: alu_bus_a = acc_q;
            endcase
        end
    end

    // Instruction latch, accumulator/flags writeback and result register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q      <= OP_LOAD;
            data_q    <= '0;
            acc_q     <= '0;
            zero_q    <= 1'b1;
            neg_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            if (accept) begin
                op_q   <= op_t'(s_op);
                data_q <= s_data;
            end
            if (state_q == EXEC && writes_acc) begin
                acc_q  <= alu_out;
                zero_q <= (alu_out == '0);
                neg_q  <= alu_out[WIDTH-1];
            end
            if (state_q == EXEC && op_q == OP_STORE) begin
                m_data_q <= acc_q;
            end
            // Valid rises on the STORE execute edge and holds until taken.
            m_valid_q <= (state_q == EXEC && op_q == OP_STORE) ||
                         (state_q == OUT && !m_ready);
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign zero     = zero_q;
    assign negative = neg_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised scoreboard bench for alu_sequencer with a behavioural ALU.
module tb_alu_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn;
    logic         s_valid;
    logic         s_ready;
    logic [2:0]   s_op;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         zero;
    logic         negative;
    logic [W-1:0] alu_bus_a;
    logic [W-1:0] alu_bus_b;
    logic [2:0]   alu_sel;
    logic [W-1:0] alu_out;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] sbq[$];
    logic [W-1:0] exp_acc  = '0;
    logic         exp_zero = 1'b1;
    logic         exp_neg  = 1'b0;
    logic         prev_hs  = 1'b0;
    logic         rand_ready = 1'b0;
    time          acc_time;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .zero(zero), .negative(negative),
        .alu_bus_a(alu_bus_a), .alu_bus_b(alu_bus_b), .alu_sel(alu_sel),
        .alu_out(alu_out)
    );

    // Behavioural ALU responding combinationally to the sequencer
    always_comb begin
        case (alu_sel)
            3'b001:  alu_out = alu_bus_a + alu_bus_b;
            3'b010:  alu_out = alu_bus_a - alu_bus_b;
            3'b011:  alu_out = alu_bus_a * alu_bus_b;
            3'b100:  alu_out = W'($signed(alu_bus_a) / 2);
            default: alu_out = alu_bus_a;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference accumulator update from the opcode definitions
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] acc,
                                           input logic [W-1:0] d);
        int a = $signed(acc);
        int b = $signed(d);
        int r;
        case (op)
            3'd0:    r = b;
            3'd1:    r = a + b;
            3'd2:    r = a - b;
            3'd3:    r = a * b;
            3'd4:    r = a / 2;
            3'd5:    r = 0;
            default: r = a;
        endcase
        return r[W-1:0];
    endfunction

    // Random downstream backpressure
    always @(posedge clk) begin
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: compares the result port against the scoreboard
    always @(negedge clk) begin
        if (rstn) begin
            if (prev_hs) check("mvalid_pulse", m_valid, 0);
            if (m_valid) begin
                check("busy_sready", s_ready, 0);
                if (sbq.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("m_data", m_data, sbq[0]);
                    if (m_ready) void'(sbq.pop_front());
                end
            end
            if (s_ready) begin
                check("idle_sel", alu_sel, 0);
                check("idle_a", alu_bus_a, exp_acc);
                check("idle_b", alu_bus_b, 0);
            end
            prev_hs = m_valid && m_ready;
        end else begin
            prev_hs = 1'b0;
        end
    end

    // Issue one instruction; update the model; check flags after execute
    task automatic send(input logic [2:0] op, input logic [W-1:0] d);
        int n = 0;
        s_op = op; s_data = d; s_valid = 1'b1;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            check("accept_timeout", 0, 1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        acc_time = $time;
        #1 s_valid = 1'b0;
        exp_acc = model(op, exp_acc, d);
        if (op <= 3'd5) begin
            exp_zero = (exp_acc == '0);
            exp_neg  = exp_acc[W-1];
        end
        if (op == 3'd6) sbq.push_back(exp_acc);
        @(posedge clk);
        #1;
        check("zero", zero, exp_zero);
        check("negative", negative, exp_neg);
        @(negedge clk);
    endtask

    initial begin
        time t_prev;
        rstn = 1'b0; s_valid = 1'b0; s_op = '0; s_data = '0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sready", s_ready, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_mdata", m_data, 0);
        check("rst_zero", zero, 1);
        check("rst_neg", negative, 0);
        #2 rstn = 1'b1;
        @(negedge clk);

        // T1
        send(3'd0, 8'd5); send(3'd1, 8'd3); send(3'd6, 8'd0);
        // T2
        send(3'd0, 8'd5); send(3'd2, 8'd7); send(3'd6, 8'd0);
        send(3'd4, 8'd0); send(3'd6, 8'd0); send(3'd4, 8'd0); send(3'd6, 8'd0);
        // T3
        send(3'd0, 8'd16);  send(3'd3, 8'd16); send(3'd6, 8'd0);
        send(3'd0, 8'd127); send(3'd1, 8'd1);  send(3'd6, 8'd0);
        send(3'd0, 8'hFC);  send(3'd3, 8'd3);  send(3'd6, 8'd0);
        send(3'd0, 8'hF9);  send(3'd4, 8'd0);  send(3'd6, 8'd0);

        // T4: held result, blocked input
        send(3'd0, 8'd9);
        m_ready = 1'b0;
        send(3'd6, 8'd0);
        s_op = 3'd0; s_data = 8'd77; s_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("held_mvalid", m_valid, 1);
            check("held_sready", s_ready, 0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("out_to_idle", s_ready, 1);
        send(3'd1, 8'd1); send(3'd6, 8'd0);

        // T5: back-to-back throughput
        send(3'd5, 8'd0);
        t_prev = acc_time;
        for (int i = 0; i < 4; i++) begin
            send(3'd1, 8'd1);
            if (i > 0) check("throughput", 32'(acc_time - t_prev), 20);
            t_prev = acc_time;
        end
        send(3'd7, 8'd0); send(3'd6, 8'd0);

        // T6: reset during OUT
        send(3'd0, 8'd42);
        m_ready = 1'b0;
        send(3'd6, 8'd0);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_mvalid", m_valid, 0);
        check("mid_rst_zero", zero, 1);
        check("mid_rst_a", alu_bus_a, 0);
        check("mid_rst_sready", s_ready, 0);
        sbq.delete();
        exp_acc = '0; exp_zero = 1'b1; exp_neg = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        send(3'd1, 8'd3); send(3'd6, 8'd0);

        // Random instruction stream with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 m_ready = 1'b1;
        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
        check("drain", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
